// File: rtl/dot2_seq_ctrl_pkg.sv
// Shared types for the dot2 sequencer. The tag pipe travels in lockstep with the
// datapath so that each result arrives together with its accumulate/emit flags.
package dot2_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // valid must stay the first field: it is the MSB of the packed tag
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  function automatic int pipe_depth(input int mult_latency, input int tree_delay);
    return mult_latency + tree_delay;
  endfunction
endpackage

// File: rtl/dot2_seq_ctrl_if.sv
// Handshake and datapath bundle between the sequencer, operand feeder, datapath and drain.
interface dot2_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
);
  localparam int RES_WIDTH = 2*DATA_WIDTH + 1;

  logic                  cfg_start;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic [LEN_WIDTH-1:0]  cfg_cnt;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a1, in_b1, in_a2, in_b2;
  logic                  dp_ena;
  logic [DATA_WIDTH-1:0] dp_a1, dp_b1, dp_a2, dp_b2;
  logic [RES_WIDTH-1:0]  dp_res;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  busy;
  logic                  done;

  modport slave (
    input  cfg_start, cfg_len, cfg_cnt, in_valid, in_a1, in_b1, in_a2, in_b2,
           dp_res, res_ready,
    output in_ready, dp_ena, dp_a1, dp_b1, dp_a2, dp_b2, res_valid, res_data,
           busy, done
  );

  modport master (
    output cfg_start, cfg_len, cfg_cnt, in_valid, in_a1, in_b1, in_a2, in_b2,
           dp_res, res_ready,
    input  in_ready, dp_ena, dp_a1, dp_b1, dp_a2, dp_b2, res_valid, res_data,
           busy, done
  );
endinterface

// File: rtl/dot2_seq_ctrl_shreg.sv
// Enabled N-bit, M-deep shift register; every stage is exposed so the owner can
// test occupancy without a separate counter.
module nBit_mLength_shiftRegister #(
  parameter int N = 3,
  parameter int M = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N-1:0]        din,
  output logic [M-1:0][N-1:0] stages,
  output logic [N-1:0]        dout
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else if (ena) begin
      stages[0] <= din;
      for (int i = 1; i < M; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[M-1];
endmodule

// File: rtl/dot2_seq_ctrl.sv
// Dot2 sequencer: issues operand quads into a fixed-latency datapath, tags each issue,
// and folds LEN results into one output, CNT outputs per job.
module dot2_seq_ctrl
  import dot2_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MULT_LATENCY = 4,
  parameter int TREE_DELAY   = 1,
  parameter int ACC_WIDTH    = 32,
  parameter int LEN_WIDTH    = 16
) (
  input logic           clk,
  input logic           rst,
  dot2_seq_ctrl_if.slave bus
);
  localparam int PIPE  = pipe_depth(MULT_LATENCY, TREE_DELAY);
  localparam int RES_W = 2*DATA_WIDTH + 1;

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   len_q, cnt_q, len_ctr, cnt_ctr;
  logic                   stall, accept, len_end, cnt_end, pipe_empty, fire, start_job;
  tag_t                   tag_in, tag_out;
  logic [PIPE-1:0][TAG_W-1:0] stages;
  logic [TAG_W-1:0]       tag_raw;
  logic signed [RES_W-1:0]     res_s;
  logic signed [ACC_WIDTH-1:0] acc, ext, acc_nxt, res_q;
  logic                   res_vld;

  // A pending, unconsumed result freezes datapath, tags and counters together
  assign stall       = res_vld & ~bus.res_ready;
  assign bus.dp_ena  = ~stall;
  assign bus.in_ready = (state == RUN) & ~stall;
  assign accept      = bus.in_valid & bus.in_ready;

  assign bus.dp_a1 = bus.in_a1;
  assign bus.dp_b1 = bus.in_b1;
  assign bus.dp_a2 = bus.in_a2;
  assign bus.dp_b2 = bus.in_b2;

  assign len_end = (len_ctr == len_q - LEN_WIDTH'(1));
  assign cnt_end = (cnt_ctr == cnt_q - LEN_WIDTH'(1));

  assign tag_in = '{valid: accept, first: (len_ctr == '0), last: len_end};

  nBit_mLength_shiftRegister #(.N(TAG_W), .M(PIPE)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .ena    (bus.dp_ena),
    .din    (tag_in),
    .stages (stages),
    .dout   (tag_raw)
  );

  assign tag_out = tag_t'(tag_raw);

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < PIPE; i++)
      if (stages[i][TAG_W-1]) pipe_empty = 1'b0;
  end

  assign fire    = tag_out.valid & bus.dp_ena;
  assign res_s   = bus.dp_res;
  assign ext     = ACC_WIDTH'(res_s);
  assign acc_nxt = tag_out.first ? ext : acc + ext;

  always_comb begin
    state_nxt = state;
    start_job = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (bus.cfg_start && bus.cfg_len != '0 && bus.cfg_cnt != '0) begin
        state_nxt = RUN;
        start_job = 1'b1;
      end
      RUN: if (accept && len_end && cnt_end) state_nxt = DRAIN;
      DRAIN: if (pipe_empty && res_vld && bus.res_ready) begin
        state_nxt = IDLE;
        bus.done  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      len_ctr <= '0;
      cnt_ctr <= '0;
    end else if (start_job) begin
      len_q   <= bus.cfg_len;
      cnt_q   <= bus.cfg_cnt;
      len_ctr <= '0;
      cnt_ctr <= '0;
    end else if (accept) begin
      if (len_end) begin
        len_ctr <= '0;
        cnt_ctr <= cnt_end ? '0 : cnt_ctr + LEN_WIDTH'(1);
      end else begin
        len_ctr <= len_ctr + LEN_WIDTH'(1);
      end
    end
  end

  // A new last result may replace one being consumed in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      res_q   <= '0;
      res_vld <= 1'b0;
    end else begin
      if (fire) acc <= acc_nxt;
      if (fire && tag_out.last) begin
        res_q   <= acc_nxt;
        res_vld <= 1'b1;
      end else if (bus.res_ready) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign bus.res_valid = res_vld;
  assign bus.res_data  = res_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dot2_seq_ctrl.sv
// Bench for dot2_seq_ctrl with a behavioural dot2 datapath of matching latency.
module tb_dot2_seq_ctrl;
  localparam int DW = 8, ML = 4, TD = 1, AW = 32, LW = 16;
  localparam int PIPE = ML + TD, RW = 2*DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot2_seq_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  dot2_seq_ctrl #(
    .DATA_WIDTH(DW), .MULT_LATENCY(ML), .TREE_DELAY(TD), .ACC_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datapath: sum formed at issue, delayed PIPE enabled cycles
  logic signed [RW-1:0] x1, y1, x2, y2, dp_sum;
  logic signed [RW-1:0] dp_pipe [PIPE];
  assign x1 = RW'($signed(bus.dp_a1));
  assign y1 = RW'($signed(bus.dp_b1));
  assign x2 = RW'($signed(bus.dp_a2));
  assign y2 = RW'($signed(bus.dp_b2));
  assign dp_sum = x1*y1 + x2*y2;
  always @(posedge clk) if (bus.dp_ena) begin
    dp_pipe[0] <= dp_sum;
    for (int i = 1; i < PIPE; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_res = dp_pipe[PIPE-1];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, done_cnt = 0;
  logic [AW-1:0] res_q [$];
  int res_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
    if (bus.res_valid && bus.res_ready) begin
      res_q.push_back(bus.res_data);
      res_cyc_q.push_back(cyc);
    end
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic send(input int a1, input int b1, input int a2, input int b2);
    int n = 0;
    bus.in_a1 = 8'(a1); bus.in_b1 = 8'(b1); bus.in_a2 = 8'(a2); bus.in_b2 = 8'(b2);
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (++n > 200) begin timeout("send"); break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic start(input int len, input int cnt);
    @(posedge clk); #1;
    bus.cfg_start = 1'b1; bus.cfg_len = LW'(len); bus.cfg_cnt = LW'(cnt);
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (res_q.size() < n) begin
      @(negedge clk);
      if (++k > 500) begin timeout("wait_results"); break; end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      if (++k > 500) begin timeout("wait_idle"); break; end
    end while (bus.busy);
  endtask

  task automatic wait_res_valid();
    int k = 0;
    do begin
      @(negedge clk);
      if (++k > 500) begin timeout("wait_res_valid"); break; end
    end while (!bus.res_valid);
  endtask

  typedef struct {
    int a1, b1, a2, b2;
    int exp;
  } vec_t;
  vec_t vecs [4];

  initial begin
    int d0;
    vecs[0] = '{a1: 0,    b1: 5,    a2: 0,    b2: -3,   exp: 0};
    vecs[1] = '{a1: 127,  b1: 127,  a2: 127,  b2: 127,  exp: 32258};
    vecs[2] = '{a1: -128, b1: -128, a2: -128, b2: -128, exp: 32768};
    vecs[3] = '{a1: -1,   b1: 1,    a2: 0,    b2: 0,    exp: -1};

    bus.cfg_start = 1'b0; bus.cfg_len = '0; bus.cfg_cnt = '0;
    bus.in_valid = 1'b0; bus.in_a1 = '0; bus.in_b1 = '0; bus.in_a2 = '0; bus.in_b2 = '0;
    bus.res_ready = 1'b1;

    repeat (8) @(negedge clk);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst dp_ena", bus.dp_ena, 1);
    chk("rst res_valid", bus.res_valid, 0);
    chk("rst res_data", bus.res_data, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    rst = 1'b0;

    // 1: LEN=2, CNT=1
    res_q.delete(); res_cyc_q.delete(); d0 = done_cnt;
    start(2, 1);
    send(1, 2, 3, 4);
    send(-1, 5, 2, 2);
    wait_results(1);
    wait_idle();
    chk("t1 count", res_q.size(), 1);
    if (res_q.size() > 0) begin
      chk("t1 data", res_q[0], 13);
      chk("t1 latency", res_cyc_q[0] - acc_cyc, PIPE + 1);
    end
    chk("t1 done", done_cnt - d0, 1);

    // 2: LEN=1, CNT=4, table-driven, one result per cycle
    res_q.delete(); res_cyc_q.delete();
    start(1, 4);
    for (int i = 0; i < 4; i++) send(vecs[i].a1, vecs[i].b1, vecs[i].a2, vecs[i].b2);
    wait_results(4);
    wait_idle();
    chk("t2 count", res_q.size(), 4);
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      chk($sformatf("t2 data[%0d]", i), res_q[i], vecs[i].exp);
      if (i > 0) chk($sformatf("t2 spacing[%0d]", i), res_cyc_q[i] - res_cyc_q[i-1], 1);
    end

    // 3: LEN=3, CNT=2, output 1 held for 5 cycles while quads wait
    res_q.delete(); res_cyc_q.delete();
    bus.res_ready = 1'b0;
    start(3, 2);
    fork
      begin
        send(1, 2, 3, 4);
        send(5, 6, -7, 8);
        send(-2, -3, 4, -5);
        wait_res_valid();
        @(posedge clk); #1;
        send(100, 100, -50, 20);
        send(127, -128, 0, 0);
        send(3, 3, 3, 3);
      end
      begin
        wait_res_valid();
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk($sformatf("t3 dp_ena stall%0d", i), bus.dp_ena, 0);
          chk($sformatf("t3 in_ready stall%0d", i), bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t3 dp_ena release", bus.dp_ena, 1);
      end
    join
    wait_results(2);
    wait_idle();
    chk("t3 count", res_q.size(), 2);
    if (res_q.size() > 1) begin
      chk("t3 sum1", res_q[0], -26);
      chk("t3 sum2", res_q[1], -7238);
    end

    // 4: bubbles every other cycle carry junk operands that must not accumulate
    res_q.delete(); res_cyc_q.delete();
    start(4, 1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 1, 1);
      bus.in_a1 = 8'd100; bus.in_b1 = 8'd100; bus.in_a2 = 8'd100; bus.in_b2 = 8'd100;
      @(posedge clk); #1;
    end
    wait_results(1);
    wait_idle();
    chk("t4 count", res_q.size(), 1);
    if (res_q.size() > 0) chk("t4 data", res_q[0], 8);

    // 5: zero-length start ignored; start during RUN ignored
    res_q.delete(); res_cyc_q.delete(); d0 = done_cnt;
    start(0, 3);
    @(negedge clk);
    chk("t5 len0 busy", bus.busy, 0);
    chk("t5 len0 in_ready", bus.in_ready, 0);
    start(2, 0);
    @(negedge clk);
    chk("t5 cnt0 busy", bus.busy, 0);
    chk("t5 no done", done_cnt - d0, 0);
    start(2, 1);
    send(2, 2, 1, 1);
    start(1, 1);
    @(negedge clk);
    chk("t5 busy in RUN", bus.busy, 1);
    @(posedge clk); #1;
    send(3, 3, 0, 0);
    wait_results(1);
    wait_idle();
    chk("t5 count", res_q.size(), 1);
    if (res_q.size() > 0) chk("t5 data", res_q[0], 14);
    chk("t5 done", done_cnt - d0, 1);

    // 6: asynchronous reset while draining, then a fresh job
    bus.res_ready = 1'b0;
    start(1, 1);
    send(9, 9, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("t6 busy pre-rst", bus.busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6 rst res_valid", bus.res_valid, 0);
    chk("t6 rst res_data", bus.res_data, 0);
    chk("t6 rst busy", bus.busy, 0);
    chk("t6 rst in_ready", bus.in_ready, 0);
    chk("t6 rst dp_ena", bus.dp_ena, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    res_q.delete(); res_cyc_q.delete();
    start(1, 1);
    send(2, 3, 0, 0);
    wait_results(1);
    wait_idle();
    repeat (PIPE + 2) @(negedge clk);
    chk("t6 count", res_q.size(), 1);
    if (res_q.size() > 0) chk("t6 data", res_q[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
